// File: rtl/instr_fetch_queue.sv
// Purpose : instruction fetch front end - drives the PC, issues word requests, buffers returned words in order.
// Latency : a response word appears on instr the cycle after imem_resp_valid (registered queue, no bypass).
// Backpressure: requests stop while buffered + in-flight words reach DEPTH; decode stalls via instr_ready.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   redirect_valid/redirect_pc   flush queue and in-flight words, restart fetch at redirect_pc
//   imem_req_valid/addr/ready    word request channel to instruction memory
//   imem_resp_valid/data         in-order response words from instruction memory
//   instr_valid/instr/instr_pc   queue head towards decode (NOP_INSTR / 0 when empty)
//   instr_ready                  decode consumes the head this cycle
module instr_fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t                q_mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop_cnt;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;

    logic req_fire;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Buffered plus in-flight words never exceed DEPTH, so a returning word
    // always has a free slot and the queue cannot overflow.
    assign imem_req_valid = rst_n && !redirect_valid &&
                            (({1'b0, count} + {1'b0, outstanding}) < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Words requested before a redirect are still owed by memory; they are
    // counted off by drop_cnt and never enter the queue.
    assign push = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_mem[head].dat : NOP_INSTR;
    assign instr_pc    = instr_valid ? q_mem[head].pc  : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[tail] <= '{dat: imem_resp_data, pc: resp_pc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Everything still owed by memory becomes a word to discard;
            // a response landing this same cycle is already accounted for.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(imem_resp_valid);
            drop_cnt    <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end

            unique case ({req_fire, imem_resp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (imem_resp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end

            if (push) begin
                tail    <= ptr_inc(tail);
                resp_pc <= resp_pc + ADDR_WIDTH'(4);
            end

            if (pop) begin
                head <= ptr_inc(head);
            end

            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
